// File: rtl/pong_field_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pong_field_engine                                                          |
// | Self-timed Pong playfield: ball, paddles, scores, serve/play/score FSM.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pong_field_engine #(
    parameter int FIELD_W     = 160,
    parameter int FIELD_H     = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int PADDLE_H    = 16,
    parameter int PL_X        = 2,
    parameter int AI_X        = FIELD_W - 3,
    parameter int BALL_STEP   = 1,
    parameter int PADDLE_STEP = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [7:0]         user_in,
    input  logic               ai_en,
    input  logic               new_game,
    output logic [X_W-1:0]     x_ball,
    output logic [Y_W-1:0]     y_ball,
    output logic [Y_W-1:0]     y_paddle,
    output logic [Y_W-1:0]     y_ai,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] ai_score,
    output logic               x_sign,
    output logic               y_sign,
    output logic               player_collision,
    output logic               ai_collision,
    output logic               player_scored,
    output logic               ai_scored,
    output logic               game_over,
    output logic               serving
);
    localparam int CNT_W = $clog2(SERVE_TICKS + 1);
    localparam int XG    = X_W + 1;
    localparam int YG    = Y_W + 1;

    localparam logic [X_W-1:0]     c_x_centre   = X_W'(FIELD_W / 2);
    localparam logic [Y_W-1:0]     c_y_centre   = Y_W'(FIELD_H / 2);
    localparam logic [Y_W-1:0]     c_pad_rst    = Y_W'((FIELD_H - PADDLE_H) / 2);
    localparam logic [Y_W-1:0]     c_pad_top    = Y_W'(FIELD_H - PADDLE_H);
    localparam logic [YG-1:0]      c_pad_max    = YG'(FIELD_H - PADDLE_H);
    localparam logic [YG-1:0]      c_pad_step   = YG'(PADDLE_STEP);
    localparam logic [YG-1:0]      c_pad_span   = YG'(PADDLE_H - 1);
    localparam logic [YG-1:0]      c_pad_half   = YG'(PADDLE_H / 2);
    localparam logic [YG-1:0]      c_ball_dy    = YG'(BALL_STEP);
    localparam logic [YG-1:0]      c_y_max      = YG'(FIELD_H - 1);
    localparam logic [Y_W-1:0]     c_y_edge     = Y_W'(FIELD_H - 1);
    localparam logic [XG-1:0]      c_ball_dx    = XG'(BALL_STEP);
    localparam logic [XG-1:0]      c_x_max      = XG'(FIELD_W - 1);
    localparam logic [X_W-1:0]     c_x_edge     = X_W'(FIELD_W - 1);
    localparam logic [XG-1:0]      c_pl_x       = XG'(PL_X);
    localparam logic [XG-1:0]      c_pl_hit     = XG'(PL_X + 1);
    localparam logic [XG-1:0]      c_ai_x       = XG'(AI_X);
    localparam logic [XG-1:0]      c_ai_hit     = XG'(AI_X - 1);
    localparam logic [SCORE_W-1:0] c_win        = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   c_serve_last = CNT_W'(SERVE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [X_W-1:0]     w_x_n;
    logic [Y_W-1:0]     w_y_n, w_pad_n, w_ai_n;
    logic [SCORE_W-1:0] w_ps_n, w_as_n;
    logic               w_xs_n, w_ys_n, w_pc_n, w_ac_n, w_psd_n, w_asd_n;

    // One guard bit on every coordinate so underflow shows up as the MSB.
    logic [XG-1:0] w_x_ext, w_x_lt, w_x_rt;
    logic [YG-1:0] w_y_ext, w_y_up, w_y_dn, w_ai_ctr;
    logic [YG-1:0] w_pad_up, w_pad_dn, w_ai_up, w_ai_dn;
    logic          w_pl_cover, w_ai_cover;

    assign w_x_ext    = {1'b0, x_ball};
    assign w_x_lt     = w_x_ext - c_ball_dx;
    assign w_x_rt     = w_x_ext + c_ball_dx;
    assign w_y_ext    = {1'b0, y_ball};
    assign w_y_up     = w_y_ext - c_ball_dy;
    assign w_y_dn     = w_y_ext + c_ball_dy;
    assign w_pad_up   = {1'b0, y_paddle} - c_pad_step;
    assign w_pad_dn   = {1'b0, y_paddle} + c_pad_step;
    assign w_ai_up    = {1'b0, y_ai} - c_pad_step;
    assign w_ai_dn    = {1'b0, y_ai} + c_pad_step;
    assign w_ai_ctr   = {1'b0, y_ai} + c_pad_half;
    assign w_pl_cover = (w_y_ext >= {1'b0, y_paddle}) && (w_y_ext <= {1'b0, y_paddle} + c_pad_span);
    assign w_ai_cover = (w_y_ext >= {1'b0, y_ai}) && (w_y_ext <= {1'b0, y_ai} + c_pad_span);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_x_n     = x_ball;
        w_y_n     = y_ball;
        w_pad_n   = y_paddle;
        w_ai_n    = y_ai;
        w_ps_n    = player_score;
        w_as_n    = ai_score;
        w_xs_n    = x_sign;
        w_ys_n    = y_sign;
        w_pc_n    = 1'b0;
        w_ac_n    = 1'b0;
        w_psd_n   = 1'b0;
        w_asd_n   = 1'b0;

        unique case (r_state)
            S_IDLE, S_OVER: begin
                if (new_game) begin
                    w_state_n = S_SERVE;
                    w_cnt_n   = '0;
                    w_ps_n    = '0;
                    w_as_n    = '0;
                    w_x_n     = c_x_centre;
                    w_y_n     = c_y_centre;
                    w_xs_n    = 1'b1;
                    w_ys_n    = ~y_sign;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    w_x_n   = c_x_centre;
                    w_y_n   = c_y_centre;
                    w_cnt_n = r_cnt + 1'b1;
                    if (w_cnt_n == c_serve_last) w_state_n = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (y_sign) begin
                        if (w_y_up[YG-1]) begin
                            w_y_n  = '0;
                            w_ys_n = 1'b0;
                        end else begin
                            w_y_n = w_y_up[Y_W-1:0];
                        end
                    end else if (w_y_dn > c_y_max) begin
                        w_y_n  = c_y_edge;
                        w_ys_n = 1'b1;
                    end else begin
                        w_y_n = w_y_dn[Y_W-1:0];
                    end

                    if (x_sign) begin
                        if ((w_x_ext > c_pl_x) && (w_x_lt[XG-1] || (w_x_lt <= c_pl_hit)) && w_pl_cover) begin
                            w_x_n  = c_pl_hit[X_W-1:0];
                            w_xs_n = 1'b0;
                            w_pc_n = 1'b1;
                        end else if (w_x_lt[XG-1]) begin
                            w_x_n   = '0;
                            w_asd_n = 1'b1;
                            w_as_n  = (ai_score >= c_win) ? ai_score : ai_score + 1'b1;
                        end else begin
                            w_x_n = w_x_lt[X_W-1:0];
                        end
                    end else begin
                        if ((w_x_ext < c_ai_x) && (w_x_rt >= c_ai_hit) && w_ai_cover) begin
                            w_x_n  = c_ai_hit[X_W-1:0];
                            w_xs_n = 1'b1;
                            w_ac_n = 1'b1;
                        end else if (w_x_rt > c_x_max) begin
                            w_x_n   = c_x_edge;
                            w_psd_n = 1'b1;
                            w_ps_n  = (player_score >= c_win) ? player_score : player_score + 1'b1;
                        end else begin
                            w_x_n = w_x_rt[X_W-1:0];
                        end
                    end

                    // Re-serve toward whoever conceded; a winning point ends the game.
                    if (w_asd_n || w_psd_n) begin
                        w_cnt_n   = '0;
                        w_xs_n    = w_asd_n;
                        w_ys_n    = ~w_ys_n;
                        w_state_n = ((w_as_n == c_win) || (w_ps_n == c_win)) ? S_OVER : S_SERVE;
                    end
                end
            end
        endcase

        if (tick && ((r_state == S_SERVE) || (r_state == S_PLAY))) begin
            if (user_in == 8'h77) begin
                w_pad_n = w_pad_up[YG-1] ? '0 : w_pad_up[Y_W-1:0];
            end else if (user_in == 8'h73) begin
                w_pad_n = (w_pad_dn > c_pad_max) ? c_pad_top : w_pad_dn[Y_W-1:0];
            end
            if (ai_en) begin
                if (w_ai_ctr < w_y_ext) begin
                    w_ai_n = (w_ai_dn > c_pad_max) ? c_pad_top : w_ai_dn[Y_W-1:0];
                end else if (w_ai_ctr > w_y_ext) begin
                    w_ai_n = w_ai_up[YG-1] ? '0 : w_ai_up[Y_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            x_ball           <= c_x_centre;
            y_ball           <= c_y_centre;
            y_paddle         <= c_pad_rst;
            y_ai             <= c_pad_rst;
            player_score     <= '0;
            ai_score         <= '0;
            x_sign           <= 1'b1;
            y_sign           <= 1'b0;
            player_collision <= 1'b0;
            ai_collision     <= 1'b0;
            player_scored    <= 1'b0;
            ai_scored        <= 1'b0;
            game_over        <= 1'b0;
            serving          <= 1'b0;
        end else begin
            r_state          <= w_state_n;
            r_cnt            <= w_cnt_n;
            x_ball           <= w_x_n;
            y_ball           <= w_y_n;
            y_paddle         <= w_pad_n;
            y_ai             <= w_ai_n;
            player_score     <= w_ps_n;
            ai_score         <= w_as_n;
            x_sign           <= w_xs_n;
            y_sign           <= w_ys_n;
            player_collision <= w_pc_n;
            ai_collision     <= w_ac_n;
            player_scored    <= w_psd_n;
            ai_scored        <= w_asd_n;
            game_over        <= (w_state_n == S_OVER);
            serving          <= (w_state_n == S_SERVE);
        end
    end
endmodule
`default_nettype wire

// File: doc/pong_field_engine.md
# pong_field_engine

Parametrised successor to the Pong datapath. It owns all playfield state: ball position and direction, player and AI paddle positions, and both scores. It advances that state autonomously, once per frame `tick`, through its own serve/play/score state machine, so the external controller no longer drives per-register enables and selects. It sits between the keyboard/UART byte source (`user_in`) and the VGA renderer, which consumes the position and score outputs.

## Interface
Parameters:
- `FIELD_W`, 160: playfield width in pixels; x range is 0..FIELD_W-1.
- `FIELD_H`, 120: playfield height; y range is 0..FIELD_H-1.
- `X_W`, 8: x register width; must satisfy 2^X_W ≥ FIELD_W.
- `Y_W`, 7: y register width; must satisfy 2^Y_W ≥ FIELD_H.
- `PADDLE_H`, 16: paddle height in pixels.
- `PL_X`, 2: x column of the player paddle.
- `AI_X`, FIELD_W-3: x column of the AI paddle.
- `BALL_STEP`, 1: ball pixels moved per tick on each axis.
- `PADDLE_STEP`, 2: paddle pixels moved per tick.
- `SCORE_W`, 4: score counter width.
- `WIN_SCORE`, 9: score that ends the game.
- `SERVE_TICKS`, 30: ticks the ball is held at centre before play.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `tick`  in  1  frame-advance strobe, one `clk` wide.
- `user_in`  in  8  latest key byte; 0x77 ('w') moves the paddle up, 0x73 ('s') moves it down, any other value holds.
- `ai_en`  in  1  1 = AI paddle tracks the ball; 0 = AI paddle holds.
- `new_game`  in  1  start strobe; honoured only in IDLE or OVER.
- `x_ball`  out  X_W  ball x.
- `y_ball`  out  Y_W  ball y.
- `y_paddle`, `y_ai`  out  Y_W  top row of each paddle.
- `player_score`, `ai_score`  out  SCORE_W  scores.
- `x_sign`  out  1  1 = ball moving toward the player (−x).
- `y_sign`  out  1  1 = ball moving up (−y).
- `player_collision`, `ai_collision`  out  1  one-cycle pulse on a paddle bounce.
- `player_scored`, `ai_scored`  out  1  one-cycle pulse when a point is won.
- `game_over`  out  1  level; high in OVER.
- `serving`  out  1  level; high in SERVE.

## Operation
- States: IDLE, SERVE, PLAY, OVER.
  - IDLE → SERVE on `new_game`.
  - SERVE → PLAY when the serve counter reaches SERVE_TICKS.
  - PLAY → SERVE on a point, or → OVER if that point makes a score equal WIN_SCORE.
  - OVER → SERVE on `new_game`, clearing both scores.
- State and position updates occur only on clock edges where `tick`=1. `new_game` acts on any clock edge.
- SERVE:
  - Ball held at (FIELD_W/2, FIELD_H/2).
  - Serve counter increments per tick.
  - On entry, `x_sign` is set toward the side that conceded (1 on the first serve of a game) and `y_sign` is toggled.
- PLAY, ball y:
  - Next y = y ± BALL_STEP.
  - If the result would pass 0 or FIELD_H-1, clamp to that bound and flip `y_sign`.
- PLAY, ball x moving −x:
  - If the path crosses column PL_X+1 (x > PL_X, next ≤ PL_X+1) and y_paddle ≤ y_ball ≤ y_paddle+PADDLE_H-1: set x = PL_X+1, flip `x_sign`, pulse `player_collision`.
  - Otherwise, if next < 0: set x = 0, pulse `ai_scored`, increment `ai_score`.
- PLAY, ball x moving +x: mirror of the −x rule, using AI_X-1 and `ai_collision`. Reaching FIELD_W-1 pulses `player_scored` and increments `player_score`.
- The y and x rules apply on the same tick; a wall bounce and a paddle bounce may coincide.
- Player paddle:
  - Moves in SERVE and PLAY only.
  - Saturates at 0 and at FIELD_H-PADDLE_H.
- AI paddle:
  - With `ai_en`=1, compares its centre (y_ai + PADDLE_H/2) with y_ball and steps toward it. Equal centres means hold.
  - Saturates at the same bounds as the player paddle.
- Scores saturate at WIN_SCORE and never wrap.
- All arithmetic is unsigned, with one guard bit so that underflow and overflow are detected before clamping.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - Ball at centre; `x_sign`=1, `y_sign`=0.
  - Both paddles at (FIELD_H-PADDLE_H)/2.
  - Scores 0.
  - All pulses, `game_over` and `serving` = 0.
- Position, score and pulse outputs change on the same edge as the qualifying `tick`. Pulses last exactly one `clk` cycle.
- `game_over` rises on the same edge as the scoring pulse that reaches WIN_SCORE.
- `new_game` to `serving`=1: 1 cycle. Scores read 0 on that same edge.
- Play begins SERVE_TICKS ticks after `serving` rises.
- `rst` asserted mid-game returns all registers to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset, `new_game`, then 30 ticks → `serving` is high for 30 ticks; ball stays at (80,60) until play begins; `x_sign`=1.
- Paddles placed away from the ball's row, ball travelling −x → `ai_scored` pulses once with x=0; `ai_score` 0→1; state returns to SERVE with `x_sign`=1.
- y_paddle=52 and ball arriving at x=3, y=60, moving −x → `player_collision` pulses; x=3; `x_sign`=0; no score change.
- Ball at y=1 moving up with BALL_STEP=2 → y clamps to 0 and `y_sign`=0 on the same tick.
- `user_in`=0x77 held for 40 ticks → y_paddle decreases by 2 per tick and saturates at 0. `user_in`=0x73 → y_paddle saturates at 104.
- `ai_score` forced to 8, then an AI point → `ai_score`=9 and `game_over`=1 on the same edge; further ticks are frozen; `new_game` → scores 0 and `serving`=1.
